// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR filter blocks.
// Holds default widths, the accumulator sizing rule and the standard 11-tap coefficient set.
package fir_pkg;

    localparam int NB_DEF = 8;
    localparam int NT_DEF = 10;
    localparam int SH_DEF = NB_DEF - 1;

    // Full-precision sum of nt+1 products of two nb-bit signed words.
    function automatic int acc_width(input int nb, input int nt);
        return 2 * nb + $clog2(nt + 1);
    endfunction

    localparam logic signed [7:0] STD_COEF [0:10] = '{
        -8'sd1, -8'sd2, -8'sd4, 8'sd8, 8'sd35, 8'sd50,
        8'sd35, 8'sd8, -8'sd4, -8'sd2, -8'sd1
    };

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift and clamp of a wide accumulator to NB bits.
// Shared by the filter blocks so every output stage rounds identically.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int NB = NB_DEF,
    parameter int AW = acc_width(NB_DEF, NT_DEF),
    parameter int SH = SH_DEF
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [NB-1:0] res
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] HALF = (SH > 0) ? (RW'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
    localparam logic signed [RW-1:0] MAXV = RW'((1 << (NB - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = RW'(-(1 << (NB - 1)));

    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] shf;

    always_comb begin
        rnd = RW'(acc) + HALF;
        shf = rnd >>> SH;
        res = shf[NB-1:0];
        if (shf > MAXV) begin
            res = MAXV[NB-1:0];
        end else if (shf < MINV) begin
            res = MINV[NB-1:0];
        end
    end

endmodule

// File: rtl/fir_pipe.sv
// Pipelined direct-form FIR: product stage, accumulate stage, round/saturate output stage.
// Coefficients load through a shift chain; optional warm-up gating of the output strobe.
module fir_pipe
    import fir_pkg::*;
#(
    parameter int NB     = NB_DEF,
    parameter int NT     = NT_DEF,
    parameter int SH     = NB - 1,
    parameter bit WARMUP = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic signed [NB-1:0] DIN,
    input  logic                 VIN,
    input  logic                 B_LD,
    input  logic signed [NB-1:0] B_IN,
    output logic signed [NB-1:0] DOUT,
    output logic                 VOUT
);

    localparam int AW = acc_width(NB, NT);
    localparam int PW = 2 * NB;
    localparam int FW = $clog2(NT + 2);

    logic signed [NB-1:0] taps [NT];
    logic signed [NB-1:0] coef [NT+1];
    logic signed [NB-1:0] win  [NT+1];
    logic signed [PW-1:0] prod [NT+1];
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] acc_q;
    logic signed [NB-1:0] rs_out;
    logic [FW-1:0]        fill;
    logic                 take;
    logic                 p1_v;
    logic                 p2_v;

    // The incoming sample joins the window on the same edge, so products see the
    // coefficients held before any simultaneous load.
    always_comb begin
        win[0] = DIN;
        for (int k = 1; k <= NT; k++) begin
            win[k] = taps[k-1];
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k <= NT; k++) begin
            acc_sum = acc_sum + AW'(prod[k]);
        end
    end

    assign take = VIN && (!WARMUP || (fill >= FW'(NT)));

    fir_round_sat #(
        .NB (NB),
        .AW (AW),
        .SH (SH)
    ) u_round_sat (
        .acc (acc_q),
        .res (rs_out)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NT; k++) begin
                taps[k] <= '0;
            end
            for (int k = 0; k <= NT; k++) begin
                coef[k] <= '0;
                prod[k] <= '0;
            end
            fill  <= '0;
            p1_v  <= 1'b0;
            p2_v  <= 1'b0;
            acc_q <= '0;
            DOUT  <= '0;
            VOUT  <= 1'b0;
        end else begin
            if (VIN) begin
                taps[0] <= DIN;
                for (int k = 1; k < NT; k++) begin
                    taps[k] <= taps[k-1];
                end
                if (fill != FW'(NT + 1)) begin
                    fill <= fill + 1'b1;
                end
                for (int k = 0; k <= NT; k++) begin
                    prod[k] <= PW'(win[k]) * PW'(coef[k]);
                end
            end
            if (B_LD) begin
                for (int k = 0; k < NT; k++) begin
                    coef[k] <= coef[k+1];
                end
                coef[NT] <= B_IN;
            end
            p1_v <= take;
            p2_v <= p1_v;
            if (p1_v) begin
                acc_q <= acc_sum;
            end
            VOUT <= p2_v;
            if (p2_v) begin
                DOUT <= rs_out;
            end
        end
    end

endmodule

// File: tb/tb_fir_pipe.sv
// Self-checking bench for fir_pipe: table-driven impulse vectors plus hand-written corner sequences,
// with a cycle-stamped scoreboard of expected outputs.
module tb_fir_pipe;

    logic              CLK;
    logic              RST;
    logic signed [7:0] DIN;
    logic              VIN;
    logic              B_LD;
    logic signed [7:0] B_IN;
    logic signed [7:0] dout0;
    logic              vout0;
    logic signed [7:0] dout1;
    logic              vout1;

    fir_pipe u0 (
        .CLK  (CLK),
        .RST  (RST),
        .DIN  (DIN),
        .VIN  (VIN),
        .B_LD (B_LD),
        .B_IN (B_IN),
        .DOUT (dout0),
        .VOUT (vout0)
    );

    fir_pipe #(.WARMUP(1'b0)) u1 (
        .CLK  (CLK),
        .RST  (RST),
        .DIN  (DIN),
        .VIN  (VIN),
        .B_LD (B_LD),
        .B_IN (B_IN),
        .DOUT (dout1),
        .VOUT (vout1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int d;
        int due;
    } exp_t;

    typedef struct {
        logic signed [7:0] din;
        bit                exp_v;
        logic signed [7:0] exp_d;
    } vec_t;

    exp_t sb [$];
    vec_t imp_tab [21];
    logic signed [7:0] coefs [11];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_d = 0;
    int u1_first = -1;
    int u1_first_d = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_vout actual=none required=%0d due=%0d now=%0d", sb[0].d, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (vout0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_vout actual=%0d required=no_pulse cycle=%0d", dout0, cyc);
            end else begin
                e = sb.pop_front();
                chk("vout_cycle", cyc, e.due);
                chk("dout", int'(dout0), e.d);
                last_d = e.d;
            end
        end else begin
            chk("dout_hold", int'(dout0), last_d);
        end
        if (vout1 && u1_first < 0) begin
            u1_first = cyc;
            u1_first_d = int'(dout1);
        end
    endtask

    task automatic drive(input logic signed [7:0] din, input bit vin, input bit bld,
                         input logic signed [7:0] bin, input bit expv, input int expd);
        RST = 1'b0;
        DIN = din;
        VIN = vin;
        B_LD = bld;
        B_IN = bin;
        if (vin && expv) sb.push_back('{d: expd, due: cyc + 3});
        tick();
    endtask

    // Reset with VIN and B_LD also high: reset must win over both.
    task automatic do_reset(input int n);
        RST = 1'b1;
        DIN = 8'sd99;
        VIN = 1'b1;
        B_LD = 1'b1;
        B_IN = 8'sd77;
        sb.delete();
        last_d = 0;
        u1_first = -1;
        repeat (n) tick();
        RST = 1'b0;
        VIN = 1'b0;
        B_LD = 1'b0;
    endtask

    task automatic load_coefs(input logic signed [7:0] c [11]);
        for (int i = 0; i < 11; i++) drive(8'sd0, 1'b0, 1'b1, c[i], 1'b0, 0);
    endtask

    task automatic load_const(input logic signed [7:0] v);
        for (int i = 0; i < 11; i++) drive(8'sd0, 1'b0, 1'b1, v, 1'b0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;

        coefs = '{-8'sd1, -8'sd2, -8'sd4, 8'sd8, 8'sd35, 8'sd50, 8'sd35, 8'sd8, -8'sd4, -8'sd2, -8'sd1};
        for (int i = 0; i < 10; i++) imp_tab[i] = '{din: 8'sd0, exp_v: 1'b0, exp_d: 8'sd0};
        imp_tab[10] = '{din: 8'sd127, exp_v: 1'b1, exp_d: -8'sd1};
        for (int i = 1; i < 11; i++) imp_tab[10 + i] = '{din: 8'sd0, exp_v: 1'b1, exp_d: coefs[i]};

        RST = 1'b1;
        DIN = '0;
        VIN = 1'b0;
        B_LD = 1'b0;
        B_IN = '0;

        do_reset(2);
        chk("reset_dout", int'(dout0), 0);
        chk("reset_vout", int'(vout0), 0);
        chk("reset_vout_nowarm", int'(vout1), 0);

        // Warm-up: only the 11th sample yields an output; sum of coefficients 122 rounds to 1.
        load_coefs(coefs);
        e0 = cyc + 1;
        for (int i = 0; i < 11; i++) drive(8'sd1, 1'b1, 1'b0, 8'sd0, i == 10, 1);
        repeat (3) drive(8'sd0, 1'b0, 1'b0, 8'sd0, 1'b0, 0);
        chk("nowarm_first_vout", u1_first, e0 + 2);
        chk("nowarm_first_dout", u1_first_d, 0);

        do_reset(1);
        load_coefs(coefs);

        // Impulse response, back-to-back samples.
        for (int i = 0; i < 21; i++)
            drive(imp_tab[i].din, 1'b1, 1'b0, 8'sd0, imp_tab[i].exp_v, int'(imp_tab[i].exp_d));

        // Same vectors with a gap cycle after each sample; DIN garbage while VIN=0.
        for (int i = 0; i < 21; i++) begin
            drive(imp_tab[i].din, 1'b1, 1'b0, 8'sd0, 1'b1, int'(imp_tab[i].exp_d));
            drive(8'sd55, 1'b0, 1'b0, 8'sd0, 1'b0, 0);
        end

        // Load on the same edge as a sample: old coefficients for it, shifted set afterwards.
        drive(8'sd0, 1'b1, 1'b0, 8'sd0, 1'b1, 0);
        drive(8'sd127, 1'b1, 1'b1, 8'sd0, 1'b1, -1);
        drive(8'sd0, 1'b1, 1'b0, 8'sd0, 1'b1, -4);
        drive(8'sd0, 1'b1, 1'b0, 8'sd0, 1'b1, 8);

        // Positive saturation.
        load_const(8'sd127);
        for (int i = 0; i < 11; i++) drive(8'sd127, 1'b1, 1'b0, 8'sd0, 1'b1, 127);

        // Reset mid-stream: the two in-flight samples must vanish.
        drive(8'sd127, 1'b1, 1'b0, 8'sd0, 1'b1, 127);
        do_reset(1);
        chk("mid_rst_dout", int'(dout0), 0);
        chk("mid_rst_vout", int'(vout0), 0);
        for (int i = 0; i < 11; i++) drive(8'sd127, 1'b1, 1'b0, 8'sd0, i == 10, 0);
        repeat (3) drive(8'sd0, 1'b0, 1'b0, 8'sd0, 1'b0, 0);

        // -128 * -128 over all taps saturates positive.
        do_reset(1);
        load_const(-8'sd128);
        for (int i = 0; i < 13; i++) drive(-8'sd128, 1'b1, 1'b0, 8'sd0, i >= 10, 127);
        repeat (4) drive(8'sd0, 1'b0, 1'b0, 8'sd0, 1'b0, 0);

        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_pipe.md
FIR_PIPE -- requirements
Module: fir_pipe

Interface
REQ-001 Parameter NB, default 8, signed data and coefficient width in bits.
REQ-002 Parameter NT, default 10, filter order; tap count is NT+1.
REQ-003 Parameter SH, default NB-1, output right-shift applied after accumulation.
REQ-004 Parameter WARMUP, default 1; when 1, VOUT is suppressed until the delay line is fully populated.
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 DIN  in  NB  signed input sample.
REQ-008 VIN  in  1  DIN valid; one sample is accepted per cycle with VIN=1.
REQ-009 B_LD  in  1  coefficient load strobe.
REQ-010 B_IN  in  NB  signed coefficient word, shifted in when B_LD=1.
REQ-011 DOUT  out  NB  signed filtered sample.
REQ-012 VOUT  out  1  DOUT valid, one-cycle pulse per output.

Function
REQ-013 Output y[n] SHALL be sat(round(sum over k=0..NT of c[k]*x[n-k]) >> SH).
REQ-014 Products SHALL be 2*NB bits; the accumulator SHALL be 2*NB+clog2(NT+1) bits, with no intermediate overflow.
REQ-015 Rounding SHALL add 2^(SH-1) and then arithmetic-shift right by SH (round-half-up).
REQ-016 Saturation SHALL clamp the result to [-2^(NB-1), 2^(NB-1)-1].
REQ-017 The delay line SHALL shift only on edges with VIN=1; VIN=0 cycles hold all taps unchanged.
REQ-018 Latency: VIN=1 at edge k SHALL give VOUT=1 at edge k+2, with DOUT computed from taps that include that sample.
REQ-019 Back-to-back VIN SHALL give back-to-back VOUT; throughput is one sample per cycle.
REQ-020 Coefficient load: each B_LD=1 edge shifts c[k]<=c[k+1] for k<NT and sets c[NT]<=B_IN.
REQ-021 After NT+1 consecutive loads, the first word loaded SHALL be c[0].
REQ-022 B_LD and VIN high together: the sample SHALL be filtered with the coefficients held before that edge; the shift takes effect from the next sample onward.
REQ-023 A fill counter SHALL count accepted samples and saturate at NT+1.
REQ-024 With WARMUP=1, VOUT SHALL stay 0 for the first NT accepted samples after reset; the (NT+1)th sample produces the first VOUT.
REQ-025 With WARMUP=0, every accepted sample SHALL produce VOUT; unfilled taps read as 0.
REQ-026 DOUT SHALL hold its last value while VOUT=0.

Reset
REQ-027 RST=1 at an edge SHALL clear the delay line, the pipeline registers, and the fill counter to 0, and set DOUT=0 and VOUT=0.
REQ-028 RST SHALL clear all coefficients to 0.
REQ-029 RST SHALL take priority over VIN and B_LD on the same edge.
REQ-030 An in-flight sample at RST SHALL be discarded; no VOUT follows it.
REQ-031 The first edge with RST=0 SHALL accept VIN and B_LD normally.

Structure
REQ-032 A shared package fir_pkg SHALL hold the NB, NT and SH defaults, the accumulator-width function, and the standard 11-tap coefficient set.
REQ-033 Rounding and saturation SHALL live in one sub-module, fir_round_sat (inputs: accumulator; outputs: NB-bit result), reused by later filter blocks.
REQ-034 The design SHALL have no latches, no multicycle paths and no asynchronous reset.

Verification
REQ-035 Load -1,-2,-4,8,35,50,35,8,-4,-2,-1; impulse DIN=127 followed by zeros -> DOUT sequence -1,-2,-4,8,35,50,35,8,-4,-2,-1.
REQ-036 All coefficients 127, DIN=127 continuous -> DOUT=127 (positive saturation); all coefficients -128, DIN=-128 -> DOUT=127.
REQ-037 VIN toggled 1,0,1,0 with the impulse stimulus -> the same DOUT values, each VOUT exactly 2 cycles after its VIN, no extra pulses.
REQ-038 WARMUP=1, DIN=1 continuous -> VOUT first asserts 2 cycles after the 11th accepted sample; WARMUP=0 -> VOUT 2 cycles after the 1st sample.
REQ-039 B_LD and VIN high on the same edge -> that output uses the old coefficients; the next output reflects the shift.
REQ-040 RST pulsed mid-stream -> next edge DOUT=0 and VOUT=0; no VOUT for the discarded samples; coefficients read 0 until reloaded.
